serial_monitor: RTL and testbench

SERIAL_MONITOR -- requirements
Module: serial_monitor

---
 rtl/serial_monitor.sv | 196 +++++++++++++++++++
 tb/tb_serial_monitor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_monitor.sv
// Byte-serial debug monitor: parses cmd/addr/len headers from an rx FIFO and
// loads, dumps, checksums or launches code in a byte-wide memory.
module serial_monitor #(
    parameter int          ADDR_BYTES = 3,
    parameter int          LEN_BYTES  = 2,
    parameter logic [23:0] TIMEOUT    = 24'd12000000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              rx_data,
    input  logic                    rx_empty,
    output logic                    rx_read,
    output logic [7:0]              tx_data,
    output logic                    tx_write,
    input  logic                    tx_full,
    output logic [8*ADDR_BYTES-1:0] mem_raddr,
    input  logic [7:0]              mem_rdata,
    output logic [8*ADDR_BYTES-1:0] mem_waddr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_write,
    output logic                    running,
    output logic                    cpu_reset,
    output logic [8*ADDR_BYTES-1:0] start_addr,
    input  logic                    cpu_halted
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int LW = 8 * LEN_BYTES;
    localparam int FW = AW + LW;
    localparam int H  = 1 + ADDR_BYTES + LEN_BYTES;
    localparam logic [3:0] HC_LAST = 4'(H - 1);

    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] HDR     = 4'd1;
    localparam logic [3:0] DECODE  = 4'd2;
    localparam logic [3:0] LOAD    = 4'd3;
    localparam logic [3:0] DUMP_RD = 4'd4;
    localparam logic [3:0] DUMP_TX = 4'd5;
    localparam logic [3:0] SUM_RD  = 4'd6;
    localparam logic [3:0] SUM_TX  = 4'd7;
    localparam logic [3:0] ERR     = 4'd8;
    localparam logic [3:0] RUN     = 4'd9;

    logic [3:0]    state;
    logic [2:0]    cmd;
    logic [FW-1:0] fld;       // {addr, len}, shifted in big-endian
    logic [3:0]    hcnt;
    logic [23:0]   tmo;
    logic [7:0]    sum;
    logic          acc_en;
    logic          rd_dly;
    logic          tx_pend;

    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic          tx_free, can_pop, tmo_on, tmo_hit;

    assign addr     = fld[FW-1:LW];
    assign len      = fld[LW-1:0];
    // A single output slot; the push strobe goes out only while the FIFO has room.
    assign tx_write = tx_pend & ~tx_full;
    assign tx_free  = ~tx_pend | ~tx_full;
    // Skipping the cycle rx_read is high gives the FIFO a full cycle to advance its head.
    assign can_pop  = ~rx_empty & ~rx_read & tx_free;
    assign tmo_on   = (TIMEOUT != 24'd0) && (state == HDR || state == LOAD);
    assign tmo_hit  = tmo_on && (tmo == TIMEOUT - 24'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cmd        <= '0;
            fld        <= '0;
            hcnt       <= '0;
            tmo        <= '0;
            sum        <= '0;
            acc_en     <= 1'b0;
            rd_dly     <= 1'b0;
            tx_pend    <= 1'b0;
            rx_read    <= 1'b0;
            tx_data    <= '0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            mem_write  <= 1'b0;
            running    <= 1'b0;
            cpu_reset  <= 1'b0;
            start_addr <= '0;
        end else begin
            rx_read   <= 1'b0;
            mem_write <= 1'b0;
            cpu_reset <= 1'b0;
            if (tx_write) tx_pend <= 1'b0;
            tmo <= tmo_on ? tmo + 24'd1 : '0;
            case (state)
                IDLE: if (can_pop) begin
                    rx_read <= 1'b1;
                    tx_pend <= 1'b1;
                    tx_data <= rx_data;
                    cmd     <= rx_data[2:0];
                    hcnt    <= 4'd1;
                    tmo     <= '0;
                    state   <= HDR;
                end
                HDR: if (can_pop) begin
                    rx_read <= 1'b1;
                    tx_pend <= 1'b1;
                    tx_data <= rx_data;
                    fld     <= {fld[FW-9:0], rx_data};
                    hcnt    <= hcnt + 4'd1;
                    tmo     <= '0;
                    if (hcnt == HC_LAST) state <= DECODE;
                end else if (tmo_hit) begin
                    state <= ERR;
                end
                DECODE: begin
                    sum    <= '0;
                    acc_en <= 1'b0;
                    case (cmd)
                        3'd1: state <= LOAD;
                        3'd2: state <= DUMP_RD;
                        3'd3: begin
                            start_addr <= addr;
                            cpu_reset  <= 1'b1;
                            running    <= 1'b1;
                            state      <= RUN;
                        end
                        3'd4:    state <= SUM_RD;
                        default: state <= ERR;
                    endcase
                end
                // The strobe for the last byte still lands in LOAD since len hits zero with it.
                LOAD: if (len == '0) begin
                    state <= IDLE;
                end else if (can_pop) begin
                    rx_read          <= 1'b1;
                    tx_pend          <= 1'b1;
                    tx_data          <= rx_data;
                    mem_write        <= 1'b1;
                    mem_waddr        <= addr;
                    mem_wdata        <= rx_data;
                    fld[FW-1:LW]     <= addr + AW'(1);
                    fld[LW-1:0]      <= len - LW'(1);
                    tmo              <= '0;
                end else if (tmo_hit) begin
                    state <= ERR;
                end
                DUMP_RD: if (len == '0) begin
                    state <= IDLE;
                end else begin
                    mem_raddr    <= addr;
                    fld[FW-1:LW] <= addr + AW'(1);
                    fld[LW-1:0]  <= len - LW'(1);
                    rd_dly       <= 1'b1;
                    state        <= DUMP_TX;
                end
                DUMP_TX: if (rd_dly) begin
                    rd_dly <= 1'b0;
                end else if (tx_free) begin
                    tx_pend <= 1'b1;
                    tx_data <= mem_rdata;
                    state   <= DUMP_RD;
                end
                SUM_RD: if (len == '0) begin
                    state <= SUM_TX;
                end else begin
                    mem_raddr    <= addr;
                    fld[FW-1:LW] <= addr + AW'(1);
                    fld[LW-1:0]  <= len - LW'(1);
                    rd_dly       <= 1'b1;
                    acc_en       <= 1'b1;
                    state        <= SUM_TX;
                end
                SUM_TX: if (rd_dly) begin
                    rd_dly <= 1'b0;
                end else if (acc_en) begin
                    sum    <= sum + mem_rdata;
                    acc_en <= 1'b0;
                    state  <= SUM_RD;
                end else if (tx_free) begin
                    tx_pend <= 1'b1;
                    tx_data <= sum;
                    state   <= IDLE;
                end
                ERR: if (tx_free) begin
                    tx_pend <= 1'b1;
                    tx_data <= 8'h3F;
                    state   <= IDLE;
                end
                RUN: if (!cpu_reset && cpu_halted) begin
                    running <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_monitor.sv
// Two monitors (3/2-byte and 1/1-byte fields) against FIFO/memory models and
// a command-level reference computed from the header rules.
module tb_serial_monitor;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [7:0]  rx_data[2], tx_data[2], mem_rdata[2], mem_wdata[2];
    logic        rx_empty[2], rx_read[2], tx_write[2], tx_full[2];
    logic        mem_write[2], running[2], cpu_reset[2], cpu_halted[2];
    logic [23:0] raddr0, waddr0, start0;
    logic [7:0]  raddr1, waddr1, start1;

    serial_monitor #(.ADDR_BYTES(3), .LEN_BYTES(2), .TIMEOUT(24'd100)) dut0 (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data[0]), .rx_empty(rx_empty[0]),
        .rx_read(rx_read[0]), .tx_data(tx_data[0]), .tx_write(tx_write[0]), .tx_full(tx_full[0]),
        .mem_raddr(raddr0), .mem_rdata(mem_rdata[0]), .mem_waddr(waddr0), .mem_wdata(mem_wdata[0]),
        .mem_write(mem_write[0]), .running(running[0]), .cpu_reset(cpu_reset[0]),
        .start_addr(start0), .cpu_halted(cpu_halted[0]));

    serial_monitor #(.ADDR_BYTES(1), .LEN_BYTES(1), .TIMEOUT(24'd0)) dut1 (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data[1]), .rx_empty(rx_empty[1]),
        .rx_read(rx_read[1]), .tx_data(tx_data[1]), .tx_write(tx_write[1]), .tx_full(tx_full[1]),
        .mem_raddr(raddr1), .mem_rdata(mem_rdata[1]), .mem_waddr(waddr1), .mem_wdata(mem_wdata[1]),
        .mem_write(mem_write[1]), .running(running[1]), .cpu_reset(cpu_reset[1]),
        .start_addr(start1), .cpu_halted(cpu_halted[1]));

    logic [7:0] rxq[2][$];
    logic [7:0] txq[2][$];
    logic [7:0] expq[$], pay[$], ralog[$];
    logic [7:0] mem[int], ref_mem[int];
    int         n_cmp = 0, n_bad = 0, proto_err = 0;
    int         nwr[2];
    int         ra_m, wa_m;
    logic       stall_en[2], force_full[2];
    logic [7:0] last_ra1 = 8'h00;

    function automatic int key(int u, int a);
        return u != 0 ? ((1 << 24) | (a & 'hFF)) : (a & 'hFFFFFF);
    endfunction

    function automatic logic [7:0] rdref(int k);
        return ref_mem.exists(k) ? ref_mem[k] : 8'h00;
    endfunction

    // FIFO and synchronous-read memory models
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            ra_m = (u != 0) ? int'(raddr1) : int'(raddr0);
            wa_m = (u != 0) ? int'(waddr1) : int'(waddr0);
            if (rx_read[u]) begin
                if (rxq[u].size() == 0) proto_err++;
                else void'(rxq[u].pop_front());
            end
            if (tx_write[u]) begin
                if (tx_full[u]) proto_err++;
                txq[u].push_back(tx_data[u]);
            end
            if (mem_write[u]) begin
                mem[key(u, wa_m)] = mem_wdata[u];
                nwr[u]++;
            end
            mem_rdata[u] <= mem.exists(key(u, ra_m)) ? mem[key(u, ra_m)] : 8'h00;
        end
        if (raddr1 != last_ra1) begin
            ralog.push_back(raddr1);
            last_ra1 = raddr1;
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            tx_full[u]  = force_full[u] | (stall_en[u] & ($urandom_range(0, 3) == 0));
            rx_empty[u] = (rxq[u].size() == 0);
            rx_data[u]  = rx_empty[u] ? 8'h00 : rxq[u][0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx_read"}, rx_read[0], 0);
        chk({tag, "_tx_write"}, tx_write[0], 0);
        chk({tag, "_mem_write"}, mem_write[0], 0);
        chk({tag, "_cpu_reset"}, cpu_reset[0], 0);
        chk({tag, "_running"}, running[0], 0);
        chk({tag, "_tx_data"}, tx_data[0], 0);
        chk({tag, "_raddr"}, raddr0, 0);
        chk({tag, "_waddr"}, waddr0, 0);
        chk({tag, "_wdata"}, mem_wdata[0], 0);
        chk({tag, "_start"}, start0, 0);
        chk({tag, "_u1_addrs"}, {start1, raddr1, waddr1}, 0);
    endtask

    task automatic wait_cmp(input int u, input string tag);
        int b = 0;
        while (txq[u].size() < expq.size() && b < 3000) begin cyc(1); b++; end
        chk({tag, "_done"}, b < 3000, 1);
        cyc(12);
        chk({tag, "_cnt"}, txq[u].size(), expq.size());
        for (int i = 0; i < expq.size() && i < txq[u].size(); i++)
            chk($sformatf("%s_b%0d", tag, i), txq[u][i], expq[i]);
    endtask

    // Reference: echo header, then the command's effect on tx and memory
    task automatic run_cmd(input int u, input logic [7:0] c, input int a, input int l, input string tag);
        int ab = (u != 0) ? 1 : 3;
        int lb = (u != 0) ? 1 : 2;
        logic [7:0] s = 8'h00;
        txq[u].delete();
        expq.delete();
        expq.push_back(c);
        for (int i = ab - 1; i >= 0; i--) expq.push_back(8'(a >> (8 * i)));
        for (int i = lb - 1; i >= 0; i--) expq.push_back(8'(l >> (8 * i)));
        foreach (expq[i]) rxq[u].push_back(expq[i]);
        case (c[2:0])
            3'd1: for (int i = 0; i < l; i++) begin
                ref_mem[key(u, a + i)] = pay[i];
                expq.push_back(pay[i]);
                rxq[u].push_back(pay[i]);
            end
            3'd2: for (int i = 0; i < l; i++) expq.push_back(rdref(key(u, a + i)));
            3'd3: ;
            3'd4: begin
                for (int i = 0; i < l; i++) s = s + rdref(key(u, a + i));
                expq.push_back(s);
            end
            default: expq.push_back(8'h3F);
        endcase
        wait_cmp(u, tag);
        if (c[2:0] == 3'd1)
            for (int i = 0; i < l; i++)
                chk($sformatf("%s_mem%0d", tag, i), mem.exists(key(u, a + i)) ? mem[key(u, a + i)] : 8'hxx,
                    rdref(key(u, a + i)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int b, nrst, nrun, w0;
        reset_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            cpu_halted[u] = 1'b0; stall_en[u] = 1'b0; force_full[u] = 1'b0;
        end
        cyc(3);
        chk_zero("por");
        reset_n = 1'b1;
        cyc(2);

        pay = '{8'hAA, 8'hBB, 8'hCC};
        run_cmd(0, 8'h01, 'h1000, 3, "load");

        txq[0].delete();
        fork
            run_cmd(0, 8'h02, 'h1000, 3, "dump_stall");
            begin
                b = 0;
                while (txq[0].size() < 7 && b < 500) begin cyc(1); b++; end
                chk("stall_reach", b < 500, 1);
                force_full[0] = 1'b1;
                cyc(20);
                force_full[0] = 1'b0;
            end
        join

        mem[key(1, 'hFF)] = 8'hF0; ref_mem[key(1, 'hFF)] = 8'hF0;
        mem[key(1, 'h00)] = 8'h20; ref_mem[key(1, 'h00)] = 8'h20;
        ralog.delete();
        run_cmd(1, 8'h04, 'hFF, 2, "sum_wrap");
        chk("sum_val", expq[3], 8'h10);
        chk("sum_rd_n", ralog.size(), 2);
        if (ralog.size() == 2) begin
            chk("sum_rd0", ralog[0], 8'hFF);
            chk("sum_rd1", ralog[1], 8'h00);
        end
        run_cmd(1, 8'h04, 'h10, 0, "sum_len0");
        run_cmd(0, 8'h02, 'h1000, 0, "dump_len0");

        // Exec: one reset pulse, rx untouched while running, halt returns to IDLE
        txq[0].delete();
        expq = '{8'h03, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
        foreach (expq[i]) rxq[0].push_back(expq[i]);
        b = 0;
        while (!running[0] && b < 200) begin cyc(1); b++; end
        chk("run_up", running[0], 1);
        rxq[0].push_back(8'h07);
        nrst = 0;
        for (int i = 0; i < 8; i++) begin nrst += int'(cpu_reset[0]); cyc(1); end
        chk("run_rst_pulse", nrst, 1);
        chk("run_start", start0, 24'h002000);
        chk("run_hold", running[0], 1);
        chk("run_norx", rxq[0].size(), 1);
        chk("run_echo_n", txq[0].size(), 6);
        for (int i = 0; i < 6 && i < txq[0].size(); i++) chk($sformatf("run_echo%0d", i), txq[0][i], expq[i]);
        txq[0].delete();
        cpu_halted[0] = 1'b1; cyc(1); cpu_halted[0] = 1'b0;
        cyc(3);
        chk("run_down", running[0], 0);
        for (int i = 0; i < 5; i++) rxq[0].push_back(8'h00);
        expq = '{8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3F};
        wait_cmp(0, "after_run_err");

        cpu_halted[0] = 1'b1;
        fork
            run_cmd(0, 8'h03, 'h40, 0, "exec_halted");
            begin
                nrun = 0;
                for (int i = 0; i < 60; i++) begin nrun += int'(running[0]); cyc(1); end
            end
        join
        cpu_halted[0] = 1'b0;
        chk("run_ignore_first", (nrun >= 2) && (nrun <= 3), 1);
        chk("run_start2", start0, 24'h000040);

        // Timeout on a partial header, then a normal dump
        txq[0].delete();
        rxq[0].push_back(8'h01); rxq[0].push_back(8'h00);
        b = 0;
        while (txq[0].size() < 2 && b < 100) begin cyc(1); b++; end
        b = 0;
        while (txq[0].size() < 3 && b < 400) begin cyc(1); b++; end
        chk("tmo_fire", txq[0].size() >= 3, 1);
        chk("tmo_byte", txq[0].size() >= 3 ? txq[0][2] : 8'h00, 8'h3F);
        chk("tmo_not_early", b >= 95, 1);
        chk("tmo_not_late", b <= 110, 1);
        cyc(5);
        run_cmd(0, 8'h02, 'h1000, 3, "tmo_dump");

        // Async reset between edges mid-LOAD
        txq[0].delete();
        expq = '{8'h01, 8'h00, 8'h30, 8'h00, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
        foreach (expq[i]) rxq[0].push_back(expq[i]);
        w0 = nwr[0];
        b = 0;
        while (nwr[0] < w0 + 2 && b < 300) begin cyc(1); b++; end
        chk("rst_reach", b < 300, 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1 chk_zero("arst");
        rxq[0].delete();
        cyc(2);
        reset_n = 1'b1;
        cyc(2);
        chk("rst_mem0", mem.exists('h3000) ? mem['h3000] : 8'hxx, 8'h11);
        chk("rst_mem1", mem.exists('h3001) ? mem['h3001] : 8'hxx, 8'h22);
        run_cmd(0, 8'h07, 0, 0, "rst_err");

        for (int i = 0; i < 30; i++) begin
            int u, a, l, r, lo;
            logic [7:0] c;
            u = (i % 3 == 2) ? 1 : 0;
            r = $urandom_range(0, 3);
            l = $urandom_range(0, 5);
            c = 8'($urandom) & 8'hF8;
            case (r)
                0: c = c | 8'h01;
                1: c = c | 8'h02;
                2: c = c | 8'h04;
                default: begin
                    lo = $urandom_range(4, 7);
                    if (lo == 4) lo = 0;
                    c = c | 8'(lo);
                end
            endcase
            if (u != 0) a = $urandom_range(0, 255);
            else a = (i % 5 == 0) ? 'hFFFFFD : 'h1000 + $urandom_range(0, 31);
            pay.delete();
            for (int j = 0; j < l; j++) pay.push_back(8'($urandom));
            stall_en[u] = 1'($urandom_range(0, 1));
            run_cmd(u, c, a, l, $sformatf("rnd%0d", i));
            stall_en[u] = 1'b0;
        end

        chk("protocol", proto_err, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
